// File: rtl/router_pkg.sv
// Shared types and helpers for the router output-port arbiter.
// Round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
package router_pkg;

  localparam int PORT_INJECT = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Cyclic priority picker: first requesting index at or after start_idx wins.
// With start_idx tied to 0 it degenerates to lowest-index fixed priority.
module rr_priority_picker
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = sel_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     start_idx,
  output logic [NUM_PORTS-1:0] win_onehot,
  output logic [SEL_W-1:0]     win_idx
);

  logic [SEL_W:0]   cand_sum [NUM_PORTS];
  logic [SEL_W-1:0] cand_idx [NUM_PORTS];
  logic             found;

  // cand_idx[k] is the k-th index visited when searching from start_idx
  genvar gi;
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, start_idx} + (SEL_W+1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= (SEL_W+1)'(NUM_PORTS))
                        ? SEL_W'(cand_sum[gi] - (SEL_W+1)'(NUM_PORTS))
                        : cand_sum[gi][SEL_W-1:0];
  end

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && req[cand_idx[k]]) begin
        found   = 1'b1;
        win_idx = cand_idx[k];
      end
    end
    if (found) win_onehot[win_idx] = 1'b1;
  end

endmodule

// File: rtl/router_arbiter.sv
// Output-port arbiter: grants one source per packet, held until its tail transfers.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index (self-injection) wins.
module router_arbiter
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = sel_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] tail,
  input  logic                 out_ready,
  output logic                 grant_valid,
  output logic [SEL_W-1:0]     mux_select,
  output logic [NUM_PORTS-1:0] block
);

  arb_state_t             state_q, state_d;
  logic [SEL_W-1:0]       owner_q, owner_d;
  logic [SEL_W-1:0]       start_idx;
  logic [NUM_PORTS-1:0]   win_onehot;
  logic [SEL_W-1:0]       win_idx;
  logic                   xfer;
  logic                   tail_xfer;
  logic [SEL_W-1:0]       owner_next_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  assign start_idx = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (tail_xfer) rr_ptr_d = owner_next_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  assign start_idx = '0;
`endif

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W)
  ) u_picker (
    .req        (req),
    .start_idx  (start_idx),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  assign grant_valid    = (state_q == LOCKED);
  assign mux_select     = owner_q;
  assign xfer           = grant_valid & req[owner_q] & out_ready;
  assign tail_xfer      = xfer & tail[owner_q];
  assign owner_next_idx = (owner_q == SEL_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (|win_onehot) begin
          owner_d = win_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (tail_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Only the owner moves, and only when downstream accepts; reset blocks everyone.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_block
    assign block[gi] = req[gi] &
                       ~(~rst & grant_valid & (owner_q == SEL_W'(gi)) & out_ready);
  end

endmodule

// File: tb/tb_router_arbiter.sv
// Self-checking bench for router_arbiter (4 ports), randomized and directed,
// checked against a packet-level reference model of the arbitration rules.
module tb_router_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] tail = '0;
  logic         out_ready = 1'b1;
  logic         grant_valid;
  logic [1:0]   mux_select;
  logic [N-1:0] block;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: is a packet in progress, who owns it, where the search starts
  logic       m_locked = 1'b0;
  logic [1:0] m_owner = '0;
  logic [1:0] m_rr = '0;

  router_arbiter #(.NUM_PORTS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .tail        (tail),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .mux_select  (mux_select),
    .block       (block)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] pick(input logic [N-1:0] r, input logic [1:0] start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (int'(start) + k) % N;
      if (r[c]) return 2'(c);
    end
    return 2'd0;
  endfunction

  function automatic logic [N-1:0] exp_block();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++)
      b[i] = req[i] && !(!rst && m_locked && (int'(m_owner) == i) && out_ready);
    return b;
  endfunction

  // advance one clock and update the model from the inputs sampled at the edge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_locked = 1'b0;
      m_owner  = '0;
      m_rr     = '0;
    end else if (!m_locked) begin
      if (req != '0) begin
        m_owner  = pick(req, m_rr);
        m_locked = 1'b1;
        $display("cycle %0d: grant port %0d", cyc, m_owner);
      end
    end else if (req[m_owner] && out_ready && tail[m_owner]) begin
      m_locked = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      m_rr = 2'((int'(m_owner) + 1) % N);
`endif
      $display("cycle %0d: packet end port %0d", cyc, m_owner);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tail = '0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; tail = '0; out_ready = 1'b1;
    tick(); #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b expected 0", grant_valid); end
    checks++; if (mux_select !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", mux_select); end
    checks++; if (block !== 4'b1111) begin errors++; $display("FAIL reset_block: got %b expected 1111", block); end
    rst = 1'b0;
    tick(); #1;
    checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL post_reset_gv: got %b expected 1", grant_valid); end
    checks++; if (mux_select !== 2'd0) begin errors++; $display("FAIL post_reset_owner: got %0d expected 0", mux_select); end
    checks++; if (block !== 4'b1110) begin errors++; $display("FAIL post_reset_block: got %b expected 1110", block); end
    tail = 4'b0001;
    tick();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req = 4'b1010; tail = '0;
    tick();
    for (int f = 0; f < 3; f++) begin
      tail = (f == 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (grant_valid !== 1'b1 || mux_select !== 2'd1) begin errors++; $display("FAIL fp_flit%0d_owner: got gv=%b sel=%0d expected gv=1 sel=1", f, grant_valid, mux_select); end
      checks++; if (block !== 4'b1000) begin errors++; $display("FAIL fp_flit%0d_block: got %b expected 1000", f, block); end
      tick();
    end
    req = 4'b1000; tail = '0;
    #1;
    checks++; if (grant_valid !== 1'b0 || block !== 4'b1000) begin errors++; $display("FAIL fp_bubble: got gv=%b block=%b expected gv=0 block=1000", grant_valid, block); end
    tick(); #1;
    checks++; if (grant_valid !== 1'b1 || mux_select !== 2'd3) begin errors++; $display("FAIL fp_next_grant: got gv=%b sel=%0d expected gv=1 sel=3", grant_valid, mux_select); end
    tail = 4'b1000;
    tick();
  endtask

  task automatic test_round_robin();
    int gsel [5];
    int gcyc [5];
    int ngr;
    logic prev_gv;
    int exp_sel [5];
`ifdef ARB_ROUND_ROBIN_EN
    exp_sel = '{0, 1, 2, 3, 0};
`else
    exp_sel = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    req = 4'b1111; tail = 4'b1111; out_ready = 1'b1;
    ngr = 0; prev_gv = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (grant_valid && !prev_gv) begin
        if (ngr < 5) begin gsel[ngr] = int'(mux_select); gcyc[ngr] = cyc; end
        ngr++;
      end
      prev_gv = grant_valid;
      tick();
    end
    checks++;
    if (ngr < 5) begin
      errors++; $display("FAIL rr_grant_count: got %0d expected at least 5", ngr);
    end else begin
      for (int g = 0; g < 5; g++) begin
        checks++; if (gsel[g] != exp_sel[g]) begin errors++; $display("FAIL rr_order%0d: got %0d expected %0d", g, gsel[g], exp_sel[g]); end
        if (g > 0) begin
          checks++; if (gcyc[g] - gcyc[g-1] != 2) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 2", g, gcyc[g] - gcyc[g-1]); end
        end
      end
    end
    req = '0; tail = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [1:0] own;
    do_reset();
    req = 4'($urandom_range(1, 15)); tail = '0; out_ready = 1'b1;
    tick();
    own = m_owner;
    #1;
    checks++; if (mux_select !== own) begin errors++; $display("FAIL bp_owner: got %0d expected %0d", mux_select, own); end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (grant_valid !== 1'b1 || mux_select !== own) begin errors++; $display("FAIL bp_hold%0d: got gv=%b sel=%0d expected gv=1 sel=%0d", c, grant_valid, mux_select, own); end
      checks++; if (block !== req || block[own] !== 1'b1) begin errors++; $display("FAIL bp_block%0d: got %b expected %b", c, block, req); end
      tick();
    end
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      tail = (f == 1) ? (4'b0001 << own) : 4'b0000;
      #1;
      checks++; if (block[own] !== 1'b0 || grant_valid !== 1'b1) begin errors++; $display("FAIL bp_resume%0d: got block=%b gv=%b expected owner %0d unblocked", f, block, grant_valid, own); end
      tick();
    end
    req = '0; tail = '0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL bp_done: got gv=%b expected 0", grant_valid); end
  endtask

  task automatic test_wrap_lock();
    logic [1:0] w;
    do_reset();
    req = 4'b0100; tail = 4'b0100;
    tick(); tick();
    req = 4'b1001; tail = '0;
    tick(); #1;
`ifdef ARB_ROUND_ROBIN_EN
    w = 2'd3;
`else
    w = 2'd0;
`endif
    checks++; if (grant_valid !== 1'b1 || mux_select !== w) begin errors++; $display("FAIL wrap_first: got gv=%b sel=%0d expected gv=1 sel=%0d", grant_valid, mux_select, w); end
    req = 4'b1001 & ~(4'b0001 << w);
    #1;
    checks++; if (block !== req) begin errors++; $display("FAIL lock_block: got %b expected %b", block, req); end
    tick(); #1;
    checks++; if (grant_valid !== 1'b1 || mux_select !== w) begin errors++; $display("FAIL lock_hold: got gv=%b sel=%0d expected gv=1 sel=%0d", grant_valid, mux_select, w); end
    req = 4'b1001; tail = 4'b0001 << w;
    tick();
    tail = '0;
    tick(); #1;
    checks++; if (grant_valid !== 1'b1 || mux_select !== 2'd0) begin errors++; $display("FAIL wrap_second: got gv=%b sel=%0d expected gv=1 sel=0", grant_valid, mux_select); end
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req = 4'b0100; tail = '0;
    tick(); #1;
    checks++; if (mux_select !== 2'd2) begin errors++; $display("FAIL rmid_owner: got %0d expected 2", mux_select); end
    tick();
    rst = 1'b1; req = 4'b0110;
    #1;
    checks++; if (block !== 4'b0110) begin errors++; $display("FAIL rmid_block: got %b expected 0110", block); end
    tick(); #1;
    checks++; if (grant_valid !== 1'b0 || mux_select !== 2'd0) begin errors++; $display("FAIL rmid_idle: got gv=%b sel=%0d expected gv=0 sel=0", grant_valid, mux_select); end
    rst = 1'b0;
    tick(); #1;
    checks++; if (grant_valid !== 1'b1 || mux_select !== 2'd1) begin errors++; $display("FAIL rmid_regrant: got gv=%b sel=%0d expected gv=1 sel=1", grant_valid, mux_select); end
    tail = 4'b0010;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req       = 4'($urandom);
      tail      = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (grant_valid !== m_locked) begin errors++; $display("FAIL rand_gv cycle %0d: got %b expected %b", cyc, grant_valid, m_locked); end
      checks++; if (mux_select !== m_owner) begin errors++; $display("FAIL rand_sel cycle %0d: got %0d expected %0d", cyc, mux_select, m_owner); end
      checks++; if (block !== exp_block()) begin errors++; $display("FAIL rand_block cycle %0d: got %b expected %b", cyc, block, exp_block()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_wrap_lock();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_arbiter.md
# router_arbiter

Parametrised output-port arbiter for the network router. It selects one of NUM_PORTS input sources and locks that grant for a whole packet, from the granted flit until the tail flit transfers. Source 0 is local self-injection; sources 1..NUM_PORTS-1 are network input ports. It drives the per-port block lines and the output crossbar mux select, and supports fixed-priority or round-robin arbitration.

## Interface
- NUM_PORTS, 4, number of sources including self-injection (index 0); minimum 2
- SEL_W, $clog2(NUM_PORTS), derived width of mux_select; not overridden
- clk  input  1  router clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_PORTS  source i holds a valid flit
- tail  input  NUM_PORTS  the flit on source i is the last flit of its packet; meaningful only with req[i]
- out_ready  input  1  downstream accepts a flit this cycle
- grant_valid  output  1  a source owns the output (state LOCKED)
- mux_select  output  SEL_W  index of the owning source
- block  output  NUM_PORTS  1 = source i must hold its flit this cycle

## Operation
- States: IDLE, LOCKED. Registers: state, owner (SEL_W), rr_ptr (SEL_W).
- IDLE: if any req bit is set, pick a winner, load owner, and go to LOCKED. With no requests, stay IDLE.
- LOCKED: a transfer occurs when req[owner] & out_ready. On a transfer with tail[owner], go to IDLE and, in round-robin mode, set rr_ptr = owner+1. The pointer wraps from NUM_PORTS-1 to 0.
- LOCKED with req[owner] low: stay LOCKED. Packets are contiguous and the grant is never revoked except by rst.
- Single-flit packet: req and tail are high together; it goes LOCKED then IDLE after one transfer.
- Outputs:
  - grant_valid = (state == LOCKED).
  - mux_select = owner. It holds the last owner while IDLE.
  - block[i] = req[i] & ~(grant_valid & owner==i & out_ready). Non-requesting sources are never blocked.
- Requests arriving in the same cycle are resolved only by the selection rule. Late requesters wait; there is no pre-emption.

## Timing
- Registered state; block is combinational from the registered state, req, and out_ready.
- Latency: req rising at cycle t in IDLE gives grant_valid=1 and mux_select=winner at t+1. The first transfer can happen at t+1.
- A tail transferring at cycle t gives IDLE at t+1 and a new grant at t+2. There is exactly one bubble between packets.
- Reset values: state IDLE, owner 0, rr_ptr 0, grant_valid 0, mux_select 0. block = req while in reset.
- rst asserted mid-packet: at the next edge the arbiter returns to IDLE and rr_ptr goes to 0. The partial packet is abandoned; upstream recovery is out of scope.
- out_ready low while LOCKED: the owner is blocked and the state is held.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - The winner is the first requesting index at or after rr_ptr, searching cyclically.
  - rr_ptr advances to owner+1 mod NUM_PORTS on each tail transfer.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the lowest requesting index wins, so self-injection is highest.
  - rr_ptr is absent and the pointer logic is not synthesised.

## Structure
- Shared package router_pkg holds:
  - PORT_INJECT = 0
  - the arb_state_t enum (IDLE, LOCKED)
  - a helper function for the select width
- Sub-module rr_priority_picker (req vector and start index in; one-hot winner and index out). The fixed-priority build instantiates it with start index tied to 0.

## Test plan
- Reset: rst=1 with req=4'b1111 -> grant_valid=0, mux_select=0, block=4'b1111; one cycle after release, owner=0 and block=4'b1110 (with out_ready=1).
- Fixed priority: req=4'b1010, 3-flit packet on port 1 -> mux_select=1 for 3 transfers; port 3 blocked throughout; port 3 granted 2 cycles after port 1's tail transfers.
- Round robin (ARB_ROUND_ROBIN_EN): all four requesting single-flit packets continuously -> grant order 0,1,2,3,0, each grant 2 cycles apart.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> owner blocked, state LOCKED, mux_select stable; the packet completes once out_ready returns to 1.
- Wrap and lock: rr_ptr=3, req=4'b1001 -> port 3 wins; after its tail, port 0 wins; req[owner] dropping mid-packet keeps grant_valid=1.
- Reset mid-packet: rst pulse during the 2nd flit of port 2 -> IDLE next cycle, rr_ptr=0, then the lowest requester is re-granted.
